pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register for the pipelined CPU: generalises the fixed 32-bit IF/ID latch into a valid/ready stage usable between any two stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a DATA_W payload and has a one-cycle flush that inserts a bubble. An optional second (skid) entry gives full throughput with a registered `in_ready`. A saturating counter records cycles spent stalled by the downstream stage, for performance measurement.

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/pipe_stage_reg.sv | 138 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for pipeline stage registers
//
// Purpose: state encoding and NOP payload shared by every inter-stage
//          register in the pipelined CPU.
// Ports:   none (package).

package pipe_pkg;

   // Occupancy of a stage register. ST_SKIDFULL is only reachable when the
   // stage is built with a skid entry.
   typedef enum logic [1:0] {
      ST_EMPTY    = 2'd0,
      ST_FULL     = 2'd1,
      ST_SKIDFULL = 2'd2
   } stage_state_e;

   // Instruction-stage NOP; also the default bubble payload.
   localparam logic [31:0] NOP = 32'h0000_0000;

endpackage

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline stage register with optional skid entry
//
// Purpose: holds one (SKID=0) or two (SKID=1) payload entries between two CPU
//          pipeline stages, inserts a bubble on flush and counts downstream
//          stall cycles.
// Ports:
//   clk        in   1       rising-edge clock
//   rst        in   1       synchronous active-high reset
//   flush      in   1       drop all held entries at the next edge
//   in_valid   in   1       upstream payload present
//   in_ready   out  1       stage accepts this cycle
//   in_data    in   DATA_W  upstream payload
//   out_valid  out  1       stage presents out_data
//   out_ready  in   1       downstream accepts this cycle
//   out_data   out  DATA_W  held payload, BUBBLE_VAL when empty
//   stall_cnt  out  CNT_W   saturating count of out_valid && !out_ready cycles

module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int                 DATA_W     = 32,
   parameter logic [DATA_W-1:0]  BUBBLE_VAL = DATA_W'(NOP),
   parameter bit                 SKID       = 1'b1,
   parameter int                 CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt
);

   stage_state_e      state_q;
   logic              out_valid_q;
   logic [DATA_W-1:0] main_q;
   logic [DATA_W-1:0] skid_q;
   logic [CNT_W-1:0]  stall_q;
   logic [CNT_W-1:0]  stall_d;
   logic              in_xfer;
   logic              out_xfer;

   assign in_xfer  = in_valid && in_ready;
   assign out_xfer = out_valid_q && out_ready;

   generate
      if (SKID) begin : gen_skid
         // Ready depends only on registered state, breaking the
         // combinational out_ready -> in_ready path between stages.
         assign in_ready = !rst && (state_q != ST_SKIDFULL);

         // The second entry captures the word accepted while downstream
         // stalls the main entry.
         always_ff @(posedge clk) begin
            if (rst || flush) begin
               skid_q <= BUBBLE_VAL;
            end else if (state_q == ST_FULL && in_xfer && !out_xfer) begin
               skid_q <= in_data;
            end
         end
      end else begin : gen_noskid
         // Single entry: a full stage can only take a new word while the
         // current one leaves in the same cycle.
         assign in_ready = !rst && ((state_q == ST_EMPTY) || out_ready);
         assign skid_q   = BUBBLE_VAL;
      end
   endgenerate

   // Occupancy FSM. main_q is returned to BUBBLE_VAL whenever the stage
   // empties, so out_data can come straight from the register.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         state_q     <= ST_EMPTY;
         out_valid_q <= 1'b0;
         main_q      <= BUBBLE_VAL;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_xfer) begin
                  state_q     <= ST_FULL;
                  out_valid_q <= 1'b1;
                  main_q      <= in_data;
               end
            end
            ST_FULL: begin
               if (in_xfer && out_xfer) begin
                  main_q <= in_data;
               end else if (in_xfer) begin
                  // Only reachable with a skid entry; without one, in_ready
                  // while full implies out_ready.
                  state_q <= ST_SKIDFULL;
               end else if (out_xfer) begin
                  state_q     <= ST_EMPTY;
                  out_valid_q <= 1'b0;
                  main_q      <= BUBBLE_VAL;
               end
            end
            ST_SKIDFULL: begin
               if (out_xfer) begin
                  state_q <= ST_FULL;
                  main_q  <= skid_q;
               end
            end
            default: begin
               state_q     <= ST_EMPTY;
               out_valid_q <= 1'b0;
               main_q      <= BUBBLE_VAL;
            end
         endcase
      end
   end

   // Stall counter saturates so long measurement windows never alias to
   // small values; flush leaves it alone.
   always_comb begin
      stall_d = stall_q;
      if (out_valid_q && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
         stall_d = stall_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = main_q;
   assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg

module tb_pipe_stage_reg;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // a: SKID=1 CNT_W=16, b: SKID=0 CNT_W=16, c: SKID=1 CNT_W=4
   logic        rst_a, flush_a, iv_a, ir_a, ov_a, or_a;
   logic [31:0] id_a, od_a;
   logic [15:0] st_a;
   logic        rst_b, flush_b, iv_b, ir_b, ov_b, or_b;
   logic [31:0] id_b, od_b;
   logic [15:0] st_b;
   logic        rst_c, flush_c, iv_c, ir_c, ov_c, or_c;
   logic [31:0] id_c, od_c;
   logic [3:0]  st_c;

   pipe_stage_reg #(.DATA_W(32), .SKID(1'b1), .CNT_W(16)) u_a (
      .clk(clk), .rst(rst_a), .flush(flush_a), .in_valid(iv_a), .in_ready(ir_a),
      .in_data(id_a), .out_valid(ov_a), .out_ready(or_a), .out_data(od_a), .stall_cnt(st_a));
   pipe_stage_reg #(.DATA_W(32), .SKID(1'b0), .CNT_W(16)) u_b (
      .clk(clk), .rst(rst_b), .flush(flush_b), .in_valid(iv_b), .in_ready(ir_b),
      .in_data(id_b), .out_valid(ov_b), .out_ready(or_b), .out_data(od_b), .stall_cnt(st_b));
   pipe_stage_reg #(.DATA_W(32), .SKID(1'b1), .CNT_W(4)) u_c (
      .clk(clk), .rst(rst_c), .flush(flush_c), .in_valid(iv_c), .in_ready(ir_c),
      .in_data(id_c), .out_valid(ov_c), .out_ready(or_c), .out_data(od_c), .stall_cnt(st_c));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        rst;
      logic        flush;
      logic        iv;
      logic [31:0] din;
      logic        ordy;
      logic        e_ir;
      logic        e_ov;
      logic [31:0] e_od;
      logic [15:0] e_st;
   } vec_t;

   vec_t vecs[17];
   logic [31:0] q_a[$];
   logic [31:0] q_b[$];

   initial begin
      // rst, flush, in_valid, in_data, out_ready | in_ready, out_valid, out_data, stall_cnt
      vecs[0]  = '{1'b0, 1'b0, 1'b1, 32'hA, 1'b1, 1'b1, 1'b0, 32'h0, 16'd0};
      vecs[1]  = '{1'b0, 1'b0, 1'b1, 32'hB, 1'b0, 1'b1, 1'b1, 32'hA, 16'd0};
      vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hA, 16'd1};
      vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hA, 16'd2};
      vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'hA, 16'd3};
      vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'hB, 16'd3};
      vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 16'd3};
      vecs[7]  = '{1'b0, 1'b0, 1'b1, 32'hA, 1'b1, 1'b1, 1'b0, 32'h0, 16'd3};
      vecs[8]  = '{1'b0, 1'b0, 1'b1, 32'hB, 1'b0, 1'b1, 1'b1, 32'hA, 16'd3};
      vecs[9]  = '{1'b0, 1'b1, 1'b1, 32'hC, 1'b0, 1'b0, 1'b1, 32'hA, 16'd4};
      vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 16'd5};
      vecs[11] = '{1'b0, 1'b0, 1'b1, 32'hD, 1'b1, 1'b1, 1'b0, 32'h0, 16'd5};
      vecs[12] = '{1'b0, 1'b1, 1'b1, 32'hE, 1'b1, 1'b1, 1'b1, 32'hD, 16'd5};
      vecs[13] = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 16'd5};
      vecs[14] = '{1'b0, 1'b0, 1'b1, 32'hF, 1'b0, 1'b1, 1'b0, 32'h0, 16'd5};
      vecs[15] = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hF, 16'd5};
      vecs[16] = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 16'd0};

      // reset held two cycles with a live upstream word
      rst_a = 1; rst_b = 1; rst_c = 1;
      flush_a = 0; flush_b = 0; flush_c = 0;
      iv_a = 1; iv_b = 1; iv_c = 1;
      id_a = 32'hDEAD_BEEF; id_b = 32'hDEAD_BEEF; id_c = 32'hDEAD_BEEF;
      or_a = 0; or_b = 0; or_c = 0;
      #1;
      chk("rst_ir_a", 32'(ir_a), 0);
      chk("rst_ir_b", 32'(ir_b), 0);
      chk("rst_ir_c", 32'(ir_c), 0);
      tick();
      chk("rst2_ir_a", 32'(ir_a), 0);
      chk("rst2_ir_b", 32'(ir_b), 0);
      chk("rst_ov_a", 32'(ov_a), 0);
      chk("rst_ov_b", 32'(ov_b), 0);
      chk("rst_ov_c", 32'(ov_c), 0);
      chk("rst_od_a", od_a, 0);
      chk("rst_od_b", od_b, 0);
      chk("rst_st_a", 32'(st_a), 0);
      chk("rst_st_c", 32'(st_c), 0);
      tick();
      rst_a = 0; rst_b = 0; rst_c = 0;
      iv_a = 0; iv_b = 0; iv_c = 0;
      #1;
      chk("post_rst_ir_a", 32'(ir_a), 1);
      chk("post_rst_ir_b", 32'(ir_b), 1);
      chk("post_rst_ir_c", 32'(ir_c), 1);
      chk("post_rst_ov_a", 32'(ov_a), 0);
      chk("post_rst_st_a", 32'(st_a), 0);

      // skid stall, recovery, flush and mid-operation reset on u_a
      for (int i = 0; i < 17; i++) begin
         rst_a = vecs[i].rst; flush_a = vecs[i].flush; iv_a = vecs[i].iv;
         id_a = vecs[i].din; or_a = vecs[i].ordy;
         #1;
         chk($sformatf("vec%0d_ir", i), 32'(ir_a), 32'(vecs[i].e_ir));
         chk($sformatf("vec%0d_ov", i), 32'(ov_a), 32'(vecs[i].e_ov));
         chk($sformatf("vec%0d_od", i), od_a, vecs[i].e_od);
         chk($sformatf("vec%0d_st", i), 32'(st_a), 32'(vecs[i].e_st));
         tick();
      end
      rst_a = 0; flush_a = 0;

      // back-to-back streaming through both variants, scoreboarded
      for (int c = 0; c < 10; c++) begin
         iv_a = (c < 8); iv_b = (c < 8);
         id_a = 32'(c + 1); id_b = 32'(c + 1);
         or_a = 1; or_b = 1;
         #1;
         if (c < 8) begin
            chk($sformatf("str%0d_ir_a", c), 32'(ir_a), 1);
            chk($sformatf("str%0d_ir_b", c), 32'(ir_b), 1);
         end
         chk($sformatf("str%0d_ov_a", c), 32'(ov_a), 32'(q_a.size() != 0));
         chk($sformatf("str%0d_ov_b", c), 32'(ov_b), 32'(q_b.size() != 0));
         if (q_a.size() != 0) chk($sformatf("str%0d_od_a", c), od_a, q_a.pop_front());
         if (q_b.size() != 0) chk($sformatf("str%0d_od_b", c), od_b, q_b.pop_front());
         if (c < 8) begin
            q_a.push_back(32'(c + 1));
            q_b.push_back(32'(c + 1));
         end
         tick();
      end
      iv_a = 0; iv_b = 0;

      // single-entry stall: in_ready follows out_ready in the same cycle
      iv_b = 1; id_b = 32'h11; or_b = 1;
      #1;
      chk("ns_ir_empty", 32'(ir_b), 1);
      tick();
      id_b = 32'h22; or_b = 0;
      #1;
      chk("ns_ir_stall", 32'(ir_b), 0);
      chk("ns_od_stall", od_b, 32'h11);
      tick();
      or_b = 1;
      #1;
      chk("ns_ir_release", 32'(ir_b), 1);
      chk("ns_od_hold", od_b, 32'h11);
      chk("ns_st", 32'(st_b), 1);
      tick();
      iv_b = 0;
      #1;
      chk("ns_ov_repl", 32'(ov_b), 1);
      chk("ns_od_repl", od_b, 32'h22);
      tick();
      chk("ns_ov_drain", 32'(ov_b), 0);
      chk("ns_od_drain", od_b, 0);

      // 4-bit counter saturation, unaffected by flush
      iv_c = 1; id_c = 32'h55; or_c = 0;
      tick();
      iv_c = 0;
      for (int k = 0; k < 20; k++) begin
         #1;
         chk($sformatf("sat%0d", k), 32'(st_c), (k < 15) ? 32'(k) : 32'd15);
         tick();
      end
      flush_c = 1;
      #1;
      chk("sat_pre_flush_ov", 32'(ov_c), 1);
      chk("sat_pre_flush", 32'(st_c), 15);
      tick();
      flush_c = 0;
      #1;
      chk("sat_flush_ov", 32'(ov_c), 0);
      chk("sat_flush_od", od_c, 0);
      chk("sat_flush_st", 32'(st_c), 15);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
